// File: rtl/regfile_sequencer_if.sv
// Command and register-block bus bundle for regfile_sequencer.
//
// Signals:
//   cmd_valid/cmd_ready   command handshake (control unit -> sequencer)
//   cmd_op/rd/rs/imm      command fields: 00 WRITE, 01 READ, 10 MOVE, 11 SWAP
//   rsp_valid/rsp_data    one-cycle completion pulse and held result value
//   rf_we/iaddr/idata     register-block write port
//   rf_oe/oaddr/odata     register-block read port (odata taken from the data bus)
//
// Modports:
//   slave  - the sequencer itself
//   master - its environment: the control unit plus the register block
interface regfile_sequencer_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [DW-1:0] cmd_imm;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rf_we;
    logic [AW-1:0] rf_iaddr;
    logic [DW-1:0] rf_idata;
    logic          rf_oe;
    logic [AW-1:0] rf_oaddr;
    logic [DW-1:0] rf_odata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_odata,
        output cmd_ready, rsp_valid, rsp_data,
        output rf_we, rf_iaddr, rf_idata, rf_oe, rf_oaddr
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_odata,
        input  cmd_ready, rsp_valid, rsp_data,
        input  rf_we, rf_iaddr, rf_idata, rf_oe, rf_oaddr
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Command-driven master for an 8-entry register block. Each accepted command
// (WRITE imm, READ, MOVE, SWAP) runs as a fixed sequence of single-register
// read (RD1/RD2) and write (WR1/WR2) cycles, then pulses rsp_valid for one
// cycle with the affected value on rsp_data.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; aborts any command in flight
//   bus  - regfile_sequencer_if.slave: command handshake, response and the
//          register-block read/write ports
//
// All outputs except cmd_ready are registered, so each *_d below is the value
// the output takes during the state being entered (state_d).
module regfile_sequencer #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    regfile_sequencer_if.slave bus
);

    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpMove  = 2'b10;
    localparam logic [1:0] OpSwap  = 2'b11;

    typedef enum logic [2:0] {StIdle, StRd1, StRd2, StWr1, StWr2} state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_q, rs_q;
    logic [DW-1:0] imm_q, t0_q, t1_q;

    logic          we_q, we_d, oe_q, oe_d;
    logic [AW-1:0] iaddr_q, iaddr_d, oaddr_q, oaddr_d;
    logic [DW-1:0] idata_q, idata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic          accept;
    logic [1:0]    op_n;
    logic [AW-1:0] rd_n, rs_n;
    logic [DW-1:0] imm_n;

    assign bus.cmd_ready = (state_q == StIdle) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // Command fields as seen by the state being entered: on the accept edge the
    // latches are not yet loaded, so take them straight from the command.
    assign op_n  = accept ? bus.cmd_op  : op_q;
    assign rd_n  = accept ? bus.cmd_rd  : rd_q;
    assign rs_n  = accept ? bus.cmd_rs  : rs_q;
    assign imm_n = accept ? bus.cmd_imm : imm_q;

    // State register and datapath latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpWrite;
            rd_q        <= '0;
            rs_q        <= '0;
            imm_q       <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            iaddr_q     <= '0;
            oaddr_q     <= '0;
            idata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            iaddr_q     <= iaddr_d;
            oaddr_q     <= oaddr_d;
            idata_q     <= idata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            if (accept) begin
                op_q  <= bus.cmd_op;
                rd_q  <= bus.cmd_rd;
                rs_q  <= bus.cmd_rs;
                imm_q <= bus.cmd_imm;
            end
            if (state_q == StRd1) t0_q <= bus.rf_odata;
            if (state_q == StRd2) t1_q <= bus.rf_odata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = (bus.cmd_op == OpWrite) ? StWr1 : StRd1;
            end
            StRd1: begin
                if (op_q == OpRead)      state_d = StIdle;
                else if (op_q == OpSwap) state_d = StRd2;
                else                     state_d = StWr1;
            end
            StRd2:   state_d = StWr1;
            StWr1:   state_d = (op_q == OpSwap) ? StWr2 : StIdle;
            StWr2:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output next-values; addresses and data hold when not in use.
    always_comb begin
        we_d        = 1'b0;
        oe_d        = 1'b0;
        iaddr_d     = iaddr_q;
        oaddr_d     = oaddr_q;
        idata_d     = idata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_d)
            StRd1: begin
                oe_d    = 1'b1;
                oaddr_d = rs_n;
            end
            StRd2: begin
                oe_d    = 1'b1;
                oaddr_d = rd_q;
            end
            StWr1: begin
                we_d    = 1'b1;
                iaddr_d = rd_n;
                // MOVE enters WR1 straight from RD1, before t0 is loaded.
                if (op_n == OpWrite)      idata_d = imm_n;
                else if (state_q == StRd1) idata_d = bus.rf_odata;
                else                       idata_d = t0_q;
            end
            StWr2: begin
                we_d    = 1'b1;
                iaddr_d = rs_q;
                idata_d = t1_q;
            end
            default: ;
        endcase

        if (state_q != StIdle && state_d == StIdle) begin
            rsp_valid_d = 1'b1;
            // READ finishes out of RD1, so its value is still on the bus.
            if (op_q == OpWrite)     rsp_data_d = imm_q;
            else if (op_q == OpRead) rsp_data_d = bus.rf_odata;
            else                     rsp_data_d = t0_q;
        end
    end

    assign bus.rf_we     = we_q;
    assign bus.rf_oe     = oe_q;
    assign bus.rf_iaddr  = iaddr_q;
    assign bus.rf_oaddr  = oaddr_q;
    assign bus.rf_idata  = idata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8-entry register block.
module tb_regfile_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpMove  = 2'b10;
    localparam logic [1:0] OpSwap  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   we_cnt = 0;
    int   rsp_cnt = 0;
    logic both_seen = 1'b0;
    logic [DW-1:0] regs [2**AW];

    always #5 clk = ~clk;

    regfile_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    regfile_sequencer #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register block model; the data bus idles low when nobody drives it.
    assign bus.rf_odata = bus.rf_oe ? regs[bus.rf_oaddr] : '0;

    always @(posedge clk) begin
        if (bus.rf_we) regs[bus.rf_iaddr] <= bus.rf_idata;
        if (bus.rf_we) we_cnt <= we_cnt + 1;
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (bus.rf_we && bus.rf_oe) both_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Presents a command at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs, input logic [DW-1:0] imm);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs    = rs;
        bus.cmd_imm   = imm;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // WRITE used to preload a register; returns in the rsp_valid cycle.
    task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        issue(OpWrite, addr, 3'd0, val);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_rd    = '0;
        bus.cmd_rs    = '0;
        bus.cmd_imm   = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
            $display("FAIL rst_ready got=%b want=0", bus.cmd_ready); end
        checks++; if ({bus.rf_we, bus.rf_oe, bus.rsp_valid} !== 3'b000) begin errors++;
            $display("FAIL rst_strobes got=%b want=000", {bus.rf_we, bus.rf_oe, bus.rsp_valid}); end
        checks++; if ({bus.rf_iaddr, bus.rf_oaddr, bus.rf_idata, bus.rsp_data} !== '0) begin
            errors++; $display("FAIL rst_values got=%h want=0",
                {bus.rf_iaddr, bus.rf_oaddr, bus.rf_idata, bus.rsp_data}); end
        rst = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++;
            $display("FAIL rst_release_ready got=%b want=1", bus.cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_write();
        issue(OpWrite, 3'd2, 3'd0, 8'h5A);
        checks++; if ({bus.rf_we, bus.rf_oe} !== 2'b10) begin errors++;
            $display("FAIL wr_we_oe got=%b want=10", {bus.rf_we, bus.rf_oe}); end
        checks++; if (bus.rf_iaddr !== 3'd2 || bus.rf_idata !== 8'h5A) begin errors++;
            $display("FAIL wr_port got=%h/%h want=2/5a", bus.rf_iaddr, bus.rf_idata); end
        checks++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL wr_busy got=%b%b want=00", bus.cmd_ready, bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A) begin errors++;
            $display("FAIL wr_rsp got=%b/%h want=1/5a", bus.rsp_valid, bus.rsp_data); end
        checks++; if (bus.rf_we !== 1'b0 || regs[2] !== 8'h5A) begin errors++;
            $display("FAIL wr_commit got=%b/%h want=0/5a", bus.rf_we, regs[2]); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h5A) begin errors++;
            $display("FAIL wr_rsp_hold got=%b/%h want=0/5a", bus.rsp_valid, bus.rsp_data); end
    endtask

    task automatic test_read();
        int w0;
        w0 = we_cnt;
        issue(OpRead, 3'd0, 3'd2, 8'h00);
        checks++; if ({bus.rf_oe, bus.rf_we} !== 2'b10 || bus.rf_oaddr !== 3'd2) begin errors++;
            $display("FAIL rd_port got=%b/%h want=10/2", {bus.rf_oe, bus.rf_we}, bus.rf_oaddr); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A) begin errors++;
            $display("FAIL rd_rsp got=%b/%h want=1/5a", bus.rsp_valid, bus.rsp_data); end
        checks++; if (bus.rf_oe !== 1'b0 || we_cnt !== w0) begin errors++;
            $display("FAIL rd_no_write got=%b/%0d want=0/%0d", bus.rf_oe, we_cnt, w0); end
        @(negedge clk);
    endtask

    task automatic test_move();
        issue(OpMove, 3'd7, 3'd2, 8'h00);
        checks++; if (bus.rf_oe !== 1'b1 || bus.rf_oaddr !== 3'd2) begin errors++;
            $display("FAIL mv_rd got=%b/%h want=1/2", bus.rf_oe, bus.rf_oaddr); end
        @(negedge clk);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_iaddr !== 3'd7 || bus.rf_idata !== 8'h5A)
        begin errors++; $display("FAIL mv_wr got=%b/%h/%h want=1/7/5a",
            bus.rf_we, bus.rf_iaddr, bus.rf_idata); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A) begin errors++;
            $display("FAIL mv_rsp got=%b/%h want=1/5a", bus.rsp_valid, bus.rsp_data); end
        checks++; if (regs[7] !== 8'h5A || regs[2] !== 8'h5A) begin errors++;
            $display("FAIL mv_regs got=%h/%h want=5a/5a", regs[7], regs[2]); end
        @(negedge clk);
    endtask

    task automatic test_swap();
        load(3'd0, 8'h11);
        load(3'd1, 8'hEE);
        issue(OpSwap, 3'd1, 3'd0, 8'h00);
        checks++; if (bus.rf_oe !== 1'b1 || bus.rf_oaddr !== 3'd0 || bus.cmd_ready !== 1'b0)
        begin errors++; $display("FAIL sw_c1 got=%b/%h/%b want=1/0/0",
            bus.rf_oe, bus.rf_oaddr, bus.cmd_ready); end
        @(negedge clk);
        checks++; if (bus.rf_oe !== 1'b1 || bus.rf_oaddr !== 3'd1 || bus.cmd_ready !== 1'b0)
        begin errors++; $display("FAIL sw_c2 got=%b/%h/%b want=1/1/0",
            bus.rf_oe, bus.rf_oaddr, bus.cmd_ready); end
        @(negedge clk);
        checks++; if ({bus.rf_we, bus.rf_oe} !== 2'b10 || bus.rf_iaddr !== 3'd1 ||
            bus.rf_idata !== 8'h11) begin errors++; $display("FAIL sw_c3 got=%b/%h/%h want=10/1/11",
            {bus.rf_we, bus.rf_oe}, bus.rf_iaddr, bus.rf_idata); end
        @(negedge clk);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_iaddr !== 3'd0 || bus.rf_idata !== 8'hEE ||
            bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL sw_c4 got=%b/%h/%h want=1/0/ee",
            bus.rf_we, bus.rf_iaddr, bus.rf_idata); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h11) begin errors++;
            $display("FAIL sw_rsp got=%b/%h want=1/11", bus.rsp_valid, bus.rsp_data); end
        checks++; if (regs[0] !== 8'hEE || regs[1] !== 8'h11) begin errors++;
            $display("FAIL sw_regs got=%h/%h want=ee/11", regs[0], regs[1]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpWrite;
        bus.cmd_rd    = 3'd3;
        bus.cmd_rs    = 3'd0;
        bus.cmd_imm   = 8'h01;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_busy got=%b want=0", bus.cmd_ready); end
        bus.cmd_op = OpRead;
        bus.cmd_rd = 3'd0;
        bus.cmd_rs = 3'd3;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_overlap got=%b%b want=11", bus.rsp_valid, bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.rf_oe !== 1'b1 || bus.rf_oaddr !== 3'd3 || bus.rsp_valid !== 1'b0)
        begin errors++; $display("FAIL b2b_rd got=%b/%h/%b want=1/3/0",
            bus.rf_oe, bus.rf_oaddr, bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h01) begin errors++;
            $display("FAIL b2b_rsp got=%b/%h want=1/01", bus.rsp_valid, bus.rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_same_reg();
        load(3'd6, 8'h3C);
        issue(OpSwap, 3'd6, 3'd6, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h3C) begin errors++;
            $display("FAIL same_rsp got=%b/%h want=1/3c", bus.rsp_valid, bus.rsp_data); end
        checks++; if (regs[6] !== 8'h3C) begin errors++;
            $display("FAIL same_reg got=%h want=3c", regs[6]); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int w0;
        int r0;
        load(3'd4, 8'h44);
        load(3'd5, 8'h55);
        issue(OpSwap, 3'd5, 3'd4, 8'h00);
        @(negedge clk);
        checks++; if (bus.rf_oe !== 1'b1 || bus.rf_oaddr !== 3'd5) begin errors++;
            $display("FAIL abort_rd2 got=%b/%h want=1/5", bus.rf_oe, bus.rf_oaddr); end
        w0 = we_cnt;
        r0 = rsp_cnt;
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.rf_oe, bus.rf_we, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
            errors++; $display("FAIL abort_strobes got=%b want=0000",
                {bus.rf_oe, bus.rf_we, bus.rsp_valid, bus.cmd_ready}); end
        checks++; if ({bus.rf_oaddr, bus.rf_iaddr, bus.rf_idata, bus.rsp_data} !== '0) begin
            errors++; $display("FAIL abort_values got=%h want=0",
                {bus.rf_oaddr, bus.rf_iaddr, bus.rf_idata, bus.rsp_data}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (we_cnt !== w0 || rsp_cnt !== r0) begin errors++;
            $display("FAIL abort_quiet got=%0d/%0d want=%0d/%0d", we_cnt, rsp_cnt, w0, r0); end
        checks++; if (regs[4] !== 8'h44 || regs[5] !== 8'h55) begin errors++;
            $display("FAIL abort_regs got=%h/%h want=44/55", regs[4], regs[5]); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++;
            $display("FAIL abort_ready got=%b want=1", bus.cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_move();
        test_swap();
        test_back_to_back();
        test_same_reg();
        test_reset_abort();
        checks++; if (both_seen !== 1'b0) begin errors++;
            $display("FAIL we_oe_exclusive got=%b want=0", both_seen); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
